// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the state encodings, the drain length and the register-zero constant.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] DRAIN_CYC = 2'd3;
  localparam logic [3:0] REG_ZERO  = 4'h0;

  function automatic logic load_use(
    input logic       memread,
    input logic [3:0] rd,
    input logic [3:0] rs,
    input logic [3:0] rt,
    input logic       uses_rt
  );
    return memread && (rd != REG_ZERO) &&
           ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, cache stalls, branch flush, halt drain.
// Outputs are combinational from the state register and this cycle's inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       fd_rs,
  input  logic [3:0]       fd_rt,
  input  logic             fd_uses_rt,
  input  logic             fd_halt,
  input  logic             dx_memread,
  input  logic [3:0]       dx_rd,
  input  logic             branch_taken,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             back_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t     state, state_nx;
  logic [1:0] drain, drain_nx;
  logic       lu;

  assign lu = load_use(dx_memread, dx_rd, fd_rs, fd_rt, fd_uses_rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      drain <= '0;
    end else begin
      state <= state_nx;
      drain <= drain_nx;
    end
  end

  always_comb begin
    state_nx = state;
    drain_nx = drain;
    case (state)
      S_RUN: begin
        if (!dcache_stall && !lu && !branch_taken && fd_halt) begin
          state_nx = S_DRAIN;
          drain_nx = '0;
        end
      end
      S_DRAIN: begin
        if (!dcache_stall) begin
          drain_nx = drain + 2'd1;
          if (drain_nx == DRAIN_CYC)
            state_nx = S_HALTED;
        end
      end
      default: state_nx = S_HALTED;
    endcase
  end

  // Priority chain: a frozen pipeline beats every hazard below it.
  always_comb begin
    pc_we    = 1'b0;
    fd_we    = 1'b0;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    back_we  = 1'b0;
    halted   = 1'b0;
    if (rst) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end else if (state == S_HALTED) begin
      halted = 1'b1;
    end else if (dcache_stall) begin
      pc_we = 1'b0;
    end else if (state == S_DRAIN) begin
      fd_we    = 1'b1;
      fd_flush = 1'b1;
      back_we  = 1'b1;
    end else if (lu) begin
      dx_flush = 1'b1;
      back_we  = 1'b1;
    end else if (branch_taken) begin
      pc_we    = 1'b1;
      fd_we    = 1'b1;
      fd_flush = 1'b1;
      back_we  = 1'b1;
    end else if (fd_halt || icache_stall) begin
      fd_we    = 1'b1;
      fd_flush = 1'b1;
      back_we  = 1'b1;
    end else begin
      pc_we   = 1'b1;
      fd_we   = 1'b1;
      back_we = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (!rst && (state == S_RUN) && !pc_we),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares both a 16-bit and a 4-bit counter build.
module tb_hazard_ctrl;

  localparam logic [5:0] NRM = 6'b110010;
  localparam logic [5:0] LUB = 6'b000110;
  localparam logic [5:0] BRF = 6'b111010;
  localparam logic [5:0] ICS = 6'b011010;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] HLT = 6'b000001;
  localparam logic [5:0] RST = 6'b001100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fd_rs = '0, fd_rt = '0, dx_rd = '0;
  logic       fd_uses_rt = 0, fd_halt = 0, dx_memread = 0;
  logic       branch_taken = 0, icache_stall = 0, dcache_stall = 0;

  logic        pc_we, fd_we, fd_flush, dx_flush, back_we, halted;
  logic [15:0] stall_cnt;
  logic        pc_we4, fd_we4, fd_flush4, dx_flush4, back_we4, halted4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rt(fd_uses_rt), .fd_halt(fd_halt),
    .dx_memread(dx_memread), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .pc_we(pc_we), .fd_we(fd_we),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .back_we(back_we),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rt(fd_uses_rt), .fd_halt(fd_halt),
    .dx_memread(dx_memread), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .pc_we(pc_we4), .fd_we(fd_we4),
    .fd_flush(fd_flush4), .dx_flush(dx_flush4), .back_we(back_we4),
    .halted(halted4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    string      nm;
    logic [5:0] o;
    int         c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  task automatic v(
    input string nm, input logic r,
    input logic [3:0] rs, input logic [3:0] rt, input logic urt,
    input logic hlt, input logic mr, input logic [3:0] rd,
    input logic br, input logic ic, input logic dc,
    input logic [5:0] o, input int c
  );
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; fd_rs = rs; fd_rt = rt; fd_uses_rt = urt;
    fd_halt = hlt; dx_memread = mr; dx_rd = rd;
    branch_taken = br; icache_stall = ic; dcache_stall = dc;
    x.nm = nm; x.o = o; x.c = c;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      logic [5:0] got, got4;
      int c4;
      e = q.pop_front();
      got  = {pc_we, fd_we, fd_flush, dx_flush, back_we, halted};
      got4 = {pc_we4, fd_we4, fd_flush4, dx_flush4, back_we4, halted4};
      c4 = (e.c > 15) ? 15 : e.c;
      total += 4;
      if (got !== e.o) begin
        bad++;
        $display("FAIL %s outs: got %b want %b", e.nm, got, e.o);
      end
      if (stall_cnt !== 16'(e.c)) begin
        bad++;
        $display("FAIL %s cnt: got %0d want %0d", e.nm, stall_cnt, e.c);
      end
      if (got4 !== e.o) begin
        bad++;
        $display("FAIL %s outs4: got %b want %b", e.nm, got4, e.o);
      end
      if (stall_cnt4 !== 4'(c4)) begin
        bad++;
        $display("FAIL %s cnt4: got %0d want %0d", e.nm, stall_cnt4, c4);
      end
    end
  end

  initial begin
    //  name      r rs rt u h m rd b i d  outs  cnt
    v("reset",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0);
    v("normal",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
    v("zero_ld",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NRM, 0);
    v("lu_rs",    0, 5, 0, 0, 0, 1, 5, 0, 0, 0, LUB, 0);
    v("after_lu", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1);
    v("lu_rt",    0, 2, 7, 1, 0, 1, 7, 0, 0, 0, LUB, 1);
    v("rt_unused",0, 2, 7, 0, 0, 1, 7, 0, 0, 0, NRM, 2);
    v("br_ic",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, BRF, 2);
    v("ic_only",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ICS, 2);
    v("lu_br",    0, 5, 0, 0, 0, 1, 5, 1, 1, 0, LUB, 3);
    for (int i = 0; i < 4; i++)
      v("dc_lu",  0, 5, 0, 0, 0, 1, 5, 0, 0, 1, FRZ, 4 + i);
    v("dc_bub",   0, 5, 0, 0, 0, 1, 5, 0, 0, 0, LUB, 8);
    v("dc_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 9);
    v("halt",     0, 0, 0, 0, 1, 0, 0, 0, 0, 0, ICS, 9);
    v("drain_lu", 0, 5, 0, 0, 0, 1, 5, 1, 0, 0, ICS, 10);
    v("drain_dc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 10);
    v("drain_dc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 10);
    v("drain2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ICS, 10);
    v("drain3",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ICS, 10);
    v("halted",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, HLT, 10);
    v("halted_dc",0, 0, 0, 0, 1, 0, 0, 0, 1, 1, HLT, 10);
    v("rst_halt", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 10);
    v("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
    v("halt2",    0, 0, 0, 0, 1, 0, 0, 0, 0, 0, ICS, 0);
    v("drain_b",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ICS, 1);
    v("rst_drain",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 1);
    v("run_again",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
    for (int i = 0; i < 20; i++)
      v("sat_ic", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ICS, i);
    v("sat_end",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 20);
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: left %0d want 0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
